// File: rtl/cs_accum_cpa_if.sv
// cs_accum_cpa_if -- handshake/data bundle for the carry-save accumulator.
//   Input side : in_valid, in_ready, in_last, in_a..in_d (OP_W each)
//   Output side: out_valid, out_ready, out_data (ACC_W), busy
//   master : drives operands and out_ready (producer/consumer side)
//   slave  : the accumulator itself
interface cs_accum_cpa_if #(
    parameter int OP_W  = 16,
    parameter int ACC_W = 40
);
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic [OP_W-1:0]  in_c;
    logic [OP_W-1:0]  in_d;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_last, in_a, in_b, in_c, in_d, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_last, in_a, in_b, in_c, in_d, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/cs_accum_cpa.sv
// cs_accum_cpa -- multi-operand carry-save accumulator with a chunked CPA.
// Four unsigned operands per beat are folded into a redundant sum/carry
// pair through two rows of 4:2 compressors. The last beat of a group starts
// a CPA_W-bit-per-cycle carry-propagate pass that resolves S+C into R,
// which is then presented on out_data until the consumer accepts it.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : cs_accum_cpa_if.slave (operand beat handshake, result handshake,
//          busy status)
module cs_accum_cpa #(
    parameter int OP_W  = 16,
    parameter int ACC_W = 40,
    parameter int CPA_W = 10
) (
    input logic           clk,
    input logic           rst,
    cs_accum_cpa_if.slave bus
);
    localparam int N  = ACC_W / CPA_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_CPA,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_s;
    logic [ACC_W-1:0] r_c;
    logic [ACC_W-1:0] r_res;
    logic [KW-1:0]    r_k;
    logic             r_cy;
    logic             r_out_valid;

    logic [ACC_W-1:0] w_a, w_b, w_c, w_d;
    logic [ACC_W-1:0] w_s1, w_c1, w_s2, w_c2;
    logic [CPA_W-1:0] w_s_chunk, w_c_chunk;
    logic [CPA_W:0]   w_chunk_sum;

    // One row of 4:2 cells. cout_b of bit i feeds cin of bit i+1 (the top
    // one falls off); cout_a forms the carry vector shifted left by one.
    function automatic void cmprs_4to2(
        input  logic [ACC_W-1:0] a,
        input  logic [ACC_W-1:0] b,
        input  logic [ACC_W-1:0] c,
        input  logic [ACC_W-1:0] d,
        output logic [ACC_W-1:0] sum,
        output logic [ACC_W-1:0] carry
    );
        logic             cin;
        logic             t;
        logic             cb;
        logic [ACC_W-1:0] ca;
        cin = 1'b0;
        ca  = '0;
        sum = '0;
        for (int unsigned i = 0; i < ACC_W; i++) begin
            t      = a[i] ^ b[i] ^ c[i];
            cb     = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
            sum[i] = t ^ d[i] ^ cin;
            ca[i]  = (t & d[i]) | (t & cin) | (d[i] & cin);
            cin    = cb;
        end
        carry = ca << 1;
    endfunction

    assign w_a = ACC_W'(bus.in_a);
    assign w_b = ACC_W'(bus.in_b);
    assign w_c = ACC_W'(bus.in_c);
    assign w_d = ACC_W'(bus.in_d);

    always_comb begin
        w_s1 = '0;
        w_c1 = '0;
        w_s2 = '0;
        w_c2 = '0;
        cmprs_4to2(w_a, w_b, w_c, w_d, w_s1, w_c1);
        cmprs_4to2(w_s1, w_c1, r_s, r_c, w_s2, w_c2);
    end

    // Chunk k of S and C plus the carry from chunk k-1.
    assign w_s_chunk   = CPA_W'(r_s >> (r_k * CPA_W));
    assign w_c_chunk   = CPA_W'(r_c >> (r_k * CPA_W));
    assign w_chunk_sum = {1'b0, w_s_chunk} + {1'b0, w_c_chunk} + (CPA_W+1)'(r_cy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_s         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_k         <= '0;
            r_cy        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (bus.in_valid) begin
                        r_s <= w_s2;
                        r_c <= w_c2;
                        if (bus.in_last) begin
                            r_state <= ST_CPA;
                            r_k     <= '0;
                            r_cy    <= 1'b0;
                        end
                    end
                end
                ST_CPA: begin
                    r_res[r_k*CPA_W +: CPA_W] <= w_chunk_sum[CPA_W-1:0];
                    r_cy <= w_chunk_sum[CPA_W];
                    r_k  <= r_k + 1'b1;
                    if (r_k == KW'(N - 1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_k         <= '0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_s         <= '0;
                        r_c         <= '0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_res;
    assign bus.busy      = (r_state != ST_ACCUM) | (|r_s) | (|r_c);
endmodule
